// File: rtl/t10_keypad_pkg.sv
// Shared types and helpers for the t10 keypad scanner.
// Contents:
//   keypad_state_t - scanner FSM states
//   lowest_set_idx - index of the lowest set bit (row priority on multi-press)
//   onehot_to_idx  - binary index of a one-hot vector (column strobe)
// Both helpers take vectors up to MAX_W (8) bits, zero-extended by the caller.
package t10_keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, REPORT, RELEASE} keypad_state_t;

  localparam int MAX_W = 8;

  function automatic logic [2:0] lowest_set_idx(input logic [MAX_W-1:0] v);
    logic [2:0] idx;
    idx = '0;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_W-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/t10_keypad_if.sv
// Key-event handshake bundle between the scanner (master) and the
// downstream keypad FSM (slave).
// Signals:
//   key_valid - event available (master)
//   key_ready - consumer accepts event (slave)
//   key_code  - row_idx*COLS + col_idx
//   key_raw   - {latched_row, latched_col} snapshot
//   multi_key - more than one row bit was set in the latched snapshot
interface t10_keypad_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int KW = $clog2(ROWS * COLS);

  logic                 key_valid;
  logic                 key_ready;
  logic [KW-1:0]        key_code;
  logic [ROWS+COLS-1:0] key_raw;
  logic                 multi_key;

  modport master (output key_valid, key_code, key_raw, multi_key, input key_ready);
  modport slave  (input key_valid, key_code, key_raw, multi_key, output key_ready);
endinterface

// File: rtl/t10_sync2.sv
// Parametrised-width two-flop synchroniser with asynchronous active-high reset.
// Ports:
//   clk, rst - clock and async active-high reset
//   d_i      - asynchronous input vector
//   q_o      - synchronised output (two clk cycles later)
module t10_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/t10_keypad_scanner.sv
// Matrix keypad scanner: drives one-hot column strobes, synchronises and
// debounces the row inputs, and hands each debounced press to the consumer
// once over a valid/ready handshake.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   enable    - gates column advance and all debounce/release counting
//   read_row  - raw active-high row inputs (asynchronous)
//   scan_col  - one-hot active-high column drive
//   busy      - FSM is not in SCAN
//   kif       - key event handshake (master modport)
// Optional build macro: T10_KEYPAD_REPEAT_EN adds auto-repeat
// (parameters REPEAT_DELAY, REPEAT_RATE) while a key stays held.
module t10_keypad_scanner
  import t10_keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
`ifdef T10_KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_RATE     = 100
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [ROWS-1:0] read_row,
  output logic [COLS-1:0] scan_col,
  output logic            busy,
  t10_keypad_if.master    kif
);
  localparam int KW    = $clog2(ROWS * COLS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  keypad_state_t        state_q, state_d;
  logic [COLS-1:0]      scan_col_q, scan_col_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]     deb_cnt_q, deb_cnt_d;
  logic [ROWS-1:0]      lat_row_q, lat_row_d;
  logic [COLS-1:0]      lat_col_q, lat_col_d;
  logic [KW-1:0]        code_q, code_d;
  logic [ROWS+COLS-1:0] raw_q, raw_d;
  logic                 multi_q, multi_d;

  logic [ROWS-1:0]      row_s;
  logic [COLS-1:0]      col_next;
  logic [2:0]           row_idx, col_idx;
  logic [KW-1:0]        code_calc;
  logic                 multi_calc;

  t10_sync2 #(.W(ROWS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (read_row),
    .q_o (row_s)
  );

  // Rotate right; bit 0 wraps to the top column.
  assign col_next   = {scan_col_q[0], scan_col_q[COLS-1:1]};
  assign row_idx    = lowest_set_idx(MAX_W'(lat_row_q));
  assign col_idx    = onehot_to_idx(MAX_W'(lat_col_q));
  assign code_calc  = KW'(int'(row_idx) * COLS + int'(col_idx));
  // x & (x-1) clears the lowest set bit; anything left means a second key.
  assign multi_calc = (lat_row_q & (lat_row_q - 1'b1)) != '0;

`ifdef T10_KEYPAD_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_armed_q, rpt_armed_d;
  logic [RPT_W-1:0] rpt_last;
  // First repeat waits the long delay, later ones use the shorter rate.
  assign rpt_last = rpt_armed_q ? RPT_W'(REPEAT_RATE - 1) : RPT_W'(REPEAT_DELAY - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      scan_col_q  <= '0;
      div_cnt_q   <= '0;
      deb_cnt_q   <= '0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
      code_q      <= '0;
      raw_q       <= '0;
      multi_q     <= 1'b0;
`ifdef T10_KEYPAD_REPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      scan_col_q  <= scan_col_d;
      div_cnt_q   <= div_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      lat_row_q   <= lat_row_d;
      lat_col_q   <= lat_col_d;
      code_q      <= code_d;
      raw_q       <= raw_d;
      multi_q     <= multi_d;
`ifdef T10_KEYPAD_REPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_col_d = scan_col_q;
    div_cnt_d  = div_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    lat_row_d  = lat_row_q;
    lat_col_d  = lat_col_q;
    code_d     = code_q;
    raw_d      = raw_q;
    multi_d    = multi_q;
`ifdef T10_KEYPAD_REPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
`endif
    case (state_q)
      SCAN: begin
        if (enable) begin
          if (scan_col_q == '0) begin
            scan_col_d = {1'b1, {(COLS-1){1'b0}}};
            div_cnt_d  = '0;
          end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            // Sampling only at the end of the dwell lets the synchroniser
            // catch up with the newly driven column.
            if (row_s != '0) begin
              lat_row_d = row_s;
              lat_col_d = scan_col_q;
              deb_cnt_d = '0;
              state_d   = DEBOUNCE;
            end else begin
              scan_col_d = col_next;
            end
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (enable) begin
          if (row_s == lat_row_q) begin
            if (deb_cnt_q == DEB_LAST) begin
              code_d  = code_calc;
              raw_d   = {lat_row_q, lat_col_q};
              multi_d = multi_calc;
              state_d = REPORT;
            end else begin
              deb_cnt_d = deb_cnt_q + 1'b1;
            end
          end else begin
            scan_col_d = col_next;
            div_cnt_d  = '0;
            state_d    = SCAN;
          end
        end
      end
      REPORT: begin
        if (kif.key_ready) begin
          deb_cnt_d = '0;
          state_d   = RELEASE;
`ifdef T10_KEYPAD_REPEAT_EN
          rpt_cnt_d = '0;
`endif
        end
      end
      RELEASE: begin
        if (enable) begin
          if (row_s == '0) begin
`ifdef T10_KEYPAD_REPEAT_EN
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
`endif
            if (deb_cnt_q == DEB_LAST) begin
              scan_col_d = col_next;
              div_cnt_d  = '0;
              state_d    = SCAN;
            end else begin
              deb_cnt_d = deb_cnt_q + 1'b1;
            end
          end else begin
            deb_cnt_d = '0;
`ifdef T10_KEYPAD_REPEAT_EN
            if (row_s == lat_row_q) begin
              if (rpt_cnt_q == rpt_last) begin
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b1;
                state_d     = REPORT;
              end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
              end
            end else begin
              rpt_cnt_d = '0;
            end
`endif
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign scan_col      = scan_col_q;
  assign busy          = (state_q != SCAN);
  assign kif.key_valid = (state_q == REPORT);
  assign kif.key_code  = code_q;
  assign kif.key_raw   = raw_q;
  assign kif.multi_key = multi_q;
endmodule

// File: tb/tb_t10_keypad_scanner.sv
// Directed testbench for t10_keypad_scanner (4x4, SCAN_DIV=4, DEBOUNCE_CYCLES=4).
module tb_t10_keypad_scanner;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] read_row;
  logic [3:0] scan_col;
  logic       busy;

  t10_keypad_if #(.ROWS(ROWS), .COLS(COLS)) kif ();

  t10_keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .read_row (read_row),
    .scan_col (scan_col),
    .busy     (busy),
    .kif      (kif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int xfer_cnt  = 0;
  int valid_cnt = 0;

  always @(posedge clk) begin
    if (kif.key_valid && kif.key_ready) xfer_cnt <= xfer_cnt + 1;
    if (kif.key_valid) valid_cnt <= valid_cnt + 1;
  end

  // Wait for scan_col to newly change to pat (fresh start of that column's dwell).
  task automatic wait_col_edge(input logic [3:0] pat, input int limit, output bit ok);
    logic [3:0] prev;
    ok   = 1'b0;
    prev = scan_col;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (scan_col === pat && prev !== pat) begin
        ok = 1'b1;
        break;
      end
      prev = scan_col;
    end
  endtask

  task automatic wait_valid(input int limit, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      cyc++;
      if (kif.key_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; read_row = 4'b0100; kif.key_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (scan_col !== 4'b0000) begin bad++; $display("FAIL reset_scan_col: got %b want 0000", scan_col); end
    total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", kif.key_valid); end
    total++; if (kif.key_code !== 4'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", kif.key_code); end
    total++; if (kif.key_raw !== 8'd0) begin bad++; $display("FAIL reset_raw: got %b want 0", kif.key_raw); end
    total++; if (kif.multi_key !== 1'b0) begin bad++; $display("FAIL reset_multi: got %b want 0", kif.multi_key); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0; read_row = 4'b0000;
    @(negedge clk);
    total++; if (scan_col !== 4'b1000) begin bad++; $display("FAIL first_col: got %b want 1000", scan_col); end
    repeat (3) @(negedge clk);
    total++; if (scan_col !== 4'b1000) begin bad++; $display("FAIL dwell_col: got %b want 1000", scan_col); end
    @(negedge clk);
    total++; if (scan_col !== 4'b0100) begin bad++; $display("FAIL second_col: got %b want 0100", scan_col); end
  endtask

  task automatic test_single_press;
    bit ok; int cyc;
    wait_col_edge(4'b0010, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL press_wait_col: got timeout want col 0010"); end
    read_row = 4'b0100;
    wait_valid(40, ok, cyc);
    total++; if (!ok || cyc > 23) begin bad++; $display("FAIL press_latency: got %0d cycles (ok=%0d) want <=23", cyc, ok); end
    total++; if (kif.key_code !== 4'd9) begin bad++; $display("FAIL press_code: got %0d want 9", kif.key_code); end
    total++; if (kif.key_raw !== 8'b0100_0010) begin bad++; $display("FAIL press_raw: got %b want 01000010", kif.key_raw); end
    total++; if (kif.multi_key !== 1'b0) begin bad++; $display("FAIL press_multi: got %b want 0", kif.multi_key); end
    total++; if (busy !== 1'b1 || scan_col !== 4'b0010) begin bad++; $display("FAIL press_hold: got busy=%b col=%b want busy=1 col=0010", busy, scan_col); end
  endtask

  task automatic test_backpressure;
    bit stable; int x0; bit ok;
    x0 = xfer_cnt; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd9) stable = 1'b0;
    end
    total++; if (!stable) begin bad++; $display("FAIL bp_stable: got valid=%b code=%0d want 1/9 for 10 cycles", kif.key_valid, kif.key_code); end
    total++; if (xfer_cnt !== x0) begin bad++; $display("FAIL bp_no_xfer: got %0d want %0d", xfer_cnt, x0); end
    kif.key_ready = 1'b1;
    @(negedge clk);
    kif.key_ready = 1'b0;
    total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop: got %b want 0", kif.key_valid); end
    total++; if (xfer_cnt !== x0 + 1) begin bad++; $display("FAIL bp_one_xfer: got %0d want %0d", xfer_cnt - x0, 1); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_release_busy: got %b want 1", busy); end
    read_row = 4'b0000;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    total++; if (!ok || scan_col !== 4'b0001) begin bad++; $display("FAIL bp_resume_col: got %b (ok=%0d) want 0001", scan_col, ok); end
    total++; if (kif.key_code !== 4'd9) begin bad++; $display("FAIL bp_code_retained: got %0d want 9", kif.key_code); end
  endtask

  task automatic test_bounce;
    bit ok; bit got; int v0; logic [3:0] first_col;
    wait_col_edge(4'b0010, 40, ok);
    read_row = 4'b0100;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL bounce_enter: got busy=%b want 1", busy); end
    v0 = valid_cnt; got = 1'b0; first_col = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      read_row = ((i % 4) < 2) ? 4'b0000 : 4'b0100;
      @(negedge clk);
      if (!got && busy === 1'b0) begin got = 1'b1; first_col = scan_col; end
    end
    read_row = 4'b0000;
    repeat (12) @(negedge clk);
    total++; if (!got || first_col !== 4'b0001) begin bad++; $display("FAIL bounce_abort_col: got %b (seen=%0d) want 0001", first_col, got); end
    total++; if (valid_cnt !== v0) begin bad++; $display("FAIL bounce_no_valid: got %0d valid cycles want 0", valid_cnt - v0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bounce_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_multi_release;
    bit ok; int cyc; int x0; int v0;
    wait_col_edge(4'b1000, 40, ok);
    read_row = 4'b0110;
    wait_valid(40, ok, cyc);
    total++; if (!ok || kif.key_code !== 4'd7) begin bad++; $display("FAIL multi_code: got %0d (ok=%0d) want 7", kif.key_code, ok); end
    total++; if (kif.multi_key !== 1'b1) begin bad++; $display("FAIL multi_flag: got %b want 1", kif.multi_key); end
    total++; if (kif.key_raw !== 8'b0110_1000) begin bad++; $display("FAIL multi_raw: got %b want 01101000", kif.key_raw); end
    // Handshake must complete with enable low.
    enable = 1'b0; kif.key_ready = 1'b1;
    @(negedge clk);
    total++; if (kif.key_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL multi_xfer_noenable: got valid=%b busy=%b want 0/1", kif.key_valid, busy); end
    enable = 1'b1;
    x0 = xfer_cnt; v0 = valid_cnt;
    repeat (30) @(negedge clk);
    total++; if (xfer_cnt !== x0 || valid_cnt !== v0) begin bad++; $display("FAIL multi_hold_once: got %0d extra events want 0", xfer_cnt - x0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL multi_hold_busy: got %b want 1", busy); end
    kif.key_ready = 1'b0;
    read_row = 4'b0000;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL release_early: got busy=%b want 1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_done: got busy=%b want 0", busy); end
    total++; if (scan_col !== 4'b0100) begin bad++; $display("FAIL release_col: got %b want 0100", scan_col); end
    total++; if (kif.key_code !== 4'd7 || kif.key_raw !== 8'b0110_1000) begin bad++; $display("FAIL release_retain: got code=%0d raw=%b want 7/01101000", kif.key_code, kif.key_raw); end
  endtask

  task automatic test_enable_freeze;
    logic [3:0] c; bit moved;
    enable = 1'b0;
    c = scan_col;
    repeat (6) @(negedge clk);
    total++; if (scan_col !== c || busy !== 1'b0) begin bad++; $display("FAIL freeze_col: got %b busy=%b want %b busy=0", scan_col, busy, c); end
    enable = 1'b1;
    moved = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (scan_col !== c) begin moved = 1'b1; break; end
    end
    total++; if (!moved) begin bad++; $display("FAIL freeze_resume: got col %b stuck want advance", scan_col); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_backpressure();
    test_bounce();
    test_multi_release();
    test_enable_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/t10_keypad_scanner.md
Name: t10_keypad_scanner

Overview:
Parametrised matrix-keypad scanner for ROWS x COLS keypads. It drives one-hot column strobes, synchronises and debounces the row inputs, and encodes a single press into a binary key index. Each press is delivered once over a valid/ready handshake to the downstream keypad FSM. It adds configurable dwell, debounce, release detection, multi-key flagging and optional auto-repeat.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column strobes (2..8)
SCAN_DIV, 4, clock cycles each column is driven before advancing; must be >= 3 to cover the 2-FF synchroniser
DEBOUNCE_CYCLES, 8, consecutive stable synced samples required for press and for release (>= 1)
KW, $clog2(ROWS*COLS), key_code width (derived localparam, not overridable)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  gates column advance and debounce counting
read_row  in  ROWS  raw row inputs, active-high, asynchronous
scan_col  out  COLS  one-hot active-high column drive
key_valid  out  1  key event available
key_ready  in  1  consumer accepts event
key_code  out  KW  row_idx*COLS + col_idx (bit positions)
key_raw  out  ROWS+COLS  {latched_row, latched_col} one-hot snapshot
multi_key  out  1  latched row had more than 1 bit set
busy  out  1  FSM not in SCAN

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high, all flops clear: scan_col=0, key_valid=0, key_code=0, key_raw=0, multi_key=0, busy=0, FSM=SCAN, counters=0. rst asserted mid-operation aborts any pending event with no handshake.
- Synchroniser: read_row passes through 2 FFs to give row_s. All decisions use row_s only.
- SCAN state:
  - scan_col=0 out of reset. On the first enabled cycle it loads bit COLS-1.
  - Each column is held for SCAN_DIV enabled cycles, then the pattern shifts right. Bit 0 wraps to bit COLS-1.
  - On the last dwell cycle (div_cnt==SCAN_DIV-1), if row_s!=0: latch row_s and scan_col, clear the debounce counter, go to DEBOUNCE with the column held.
  - enable low freezes scan_col and div_cnt.
- DEBOUNCE state:
  - Each enabled cycle with row_s==latched row increments the counter.
  - Any mismatch returns to SCAN, resuming with the next column.
  - When the counter reaches DEBOUNCE_CYCLES, go to REPORT.
- REPORT state:
  - key_valid=1; key_code, key_raw and multi_key are stable while valid is high.
  - row_idx is the lowest set bit of the latched row.
  - Transfer occurs on a cycle with key_valid && key_ready. key_valid drops the next cycle, then go to RELEASE.
  - key_ready is ignored while key_valid=0. enable does not affect the handshake.
- RELEASE state:
  - Column is held. The counter counts consecutive enabled cycles with row_s==0; any nonzero sample clears it.
  - At DEBOUNCE_CYCLES, return to SCAN, advancing to the next column. Outputs key_code and key_raw retain their last values.
- busy=1 in every state except SCAN. Exactly one event is produced per debounced press.
- Latency: press stable at pins -> key_valid <= 2 + COLS*SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles, with enable high.

Optional Feature:
- Macro: T10_KEYPAD_REPEAT_EN.
- When defined: adds parameters REPEAT_DELAY (default 500) and REPEAT_RATE (default 100). In RELEASE, if row_s stays equal to the latched row for REPEAT_DELAY enabled cycles, return to REPORT and re-issue the same key_code. After that, re-issue every REPEAT_RATE cycles while the key is held. Any release-debounce progress cancels repeat.
- When undefined: no repeat logic, exactly one event per press.

Decomposition:
- Package t10_keypad_pkg holds:
  - typedef enum logic [1:0] {SCAN, DEBOUNCE, REPORT, RELEASE} keypad_state_t
  - function lowest_set_idx
  - function onehot_to_idx
- One sub-module: t10_sync2 (parametrised-width 2-FF synchroniser with async active-high reset).

Test Plan:
- Reset: hold rst 3 cycles with read_row=4'b0100 -> all outputs 0 and busy=0. Release -> scan_col=4'b1000 on the first enabled cycle, then 0100 after 4 cycles.
- Single press (ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=4): drive read_row=4'b0100 only while scan_col=4'b0010 -> key_valid with key_code=9, key_raw=8'b0100_0010, multi_key=0.
- Bounce: toggle row bit 2 every 2 cycles during DEBOUNCE -> no key_valid, FSM returns to SCAN, scan_col advances to 0001.
- Backpressure: key_ready=0 for 10 cycles -> key_valid and key_code stay constant. key_ready=1 -> valid low next cycle, exactly 1 transfer.
- Multi-key and release: read_row=4'b0110 at scan_col=1000 -> key_code=7, multi_key=1. Hold key -> no second event. Release for 4 cycles -> busy=0, scan resumes at 0100.
- With T10_KEYPAD_REPEAT_EN, REPEAT_DELAY=20, REPEAT_RATE=10: hold key_code=9 with key_ready=1 -> events at t0, t0+~20, then every ~10 cycles until release.
